rstseq: RTL and testbench

Parametrised multi-channel reset synchroniser and release sequencer. Collects NCH asynchronous active-low reset requests into the `clk_sampler` domain and holds every downstream reset asserted while any request is active. After all requests clear, it stretches assertion for a minimum width, then releases NOUT active-low reset outputs one at a time in index order with a programmable gap. Sits at the top of the sampler clock domain, feeding the synchroniser and trail logic.

---
 rtl/rstseq_pkg.sv | 15 +
 rtl/rstseq_sync.sv | 23 ++
 rtl/rstseq.sv | 143 ++++++++++++++
 tb/tb_rstseq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rstseq_pkg.sv
// Shared types and helpers for the reset release sequencer.
package rstseq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } rstseq_state_t;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rstseq_sync.sv
// One-bit multi-flop synchroniser; resets to 0 so an unsynchronised request reads as asserted.
module rstseq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_sampler,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_reg;

    always_ff @(posedge clk_sampler) begin
        if (rst) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], d};
        end
    end

    assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/rstseq.sv
// Multi-channel reset request synchroniser with minimum-width hold and staggered
// in-order release of the downstream active-low resets.
module rstseq
    import rstseq_pkg::*;
#(
    parameter int NCH         = 2,
    parameter int NOUT        = 3,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_ASSERT  = 4,
    parameter int GAP         = 3
) (
    input  logic            clk_sampler,
    input  logic            rst,
    input  logic [NCH-1:0]  rst_req_n,
    output logic [NOUT-1:0] rst_out_n,
    output logic            seq_done,
    output logic [1:0]      seq_state,
    output logic [NCH-1:0]  cause
);

    localparam int CW = $clog2(max(MIN_ASSERT, GAP) + 1);
    localparam int IW = $clog2(NOUT) + 1;

    logic [NCH-1:0]  req_s;
    logic            any_req;

    rstseq_state_t   state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic [NOUT-1:0] out_reg, out_next;
    logic            done_reg, done_next;
    logic [NCH-1:0]  cause_reg, cause_next;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_sync
            rstseq_sync #(.STAGES(SYNC_STAGES)) u_sync (
                .clk_sampler (clk_sampler),
                .rst         (rst),
                .d           (rst_req_n[gi]),
                .q           (req_s[gi])
            );
        end
    endgenerate

    assign any_req = ~&req_s;

    always_ff @(posedge clk_sampler) begin
        if (rst) begin
            state_reg <= ASSERT;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            out_reg   <= '0;
            done_reg  <= 1'b0;
            cause_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            out_reg   <= out_next;
            done_reg  <= done_next;
            cause_reg <= cause_next;
        end
    end

    // Requests always win over a terminal count in the same cycle.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        out_next   = out_reg;
        done_next  = done_reg;
        case (state_reg)
            ASSERT: begin
                out_next  = '0;
                done_next = 1'b0;
                if (!any_req) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end
            end
            HOLD: begin
                if (any_req) begin
                    state_next = ASSERT;
                end else if (cnt_reg == CW'(MIN_ASSERT - 1)) begin
                    out_next[0] = 1'b1;
                    cnt_next    = '0;
                    idx_next    = IW'(1);
                    if (NOUT == 1) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = RELEASE;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            RELEASE: begin
                if (any_req) begin
                    state_next = ASSERT;
                    out_next   = '0;
                end else if (cnt_reg == CW'(GAP - 1)) begin
                    for (int i = 0; i < NOUT; i++) begin
                        if (idx_reg == IW'(i)) out_next[i] = 1'b1;
                    end
                    cnt_next = '0;
                    if (idx_reg == IW'(NOUT - 1)) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        idx_next = idx_reg + IW'(1);
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DONE: begin
                if (any_req) begin
                    state_next = ASSERT;
                    out_next   = '0;
                    done_next  = 1'b0;
                end
            end
            default: state_next = ASSERT;
        endcase
    end

    // A fresh episode starting from RELEASE/DONE discards the previous record.
    always_comb begin
        cause_next = cause_reg;
        if (state_reg == ASSERT || state_reg == HOLD) begin
            cause_next = cause_reg | ~req_s;
        end else if (state_next == ASSERT) begin
            cause_next = ~req_s;
        end
    end

    assign rst_out_n = out_reg;
    assign seq_done  = done_reg;
    assign seq_state = state_reg;
    assign cause     = cause_reg;

endmodule

// File: tb/tb_rstseq.sv
// Table-driven check of the reset sequencer with a scoreboard queue, plus a NOUT=1 build.
module tb_rstseq;

    logic clk_sampler = 1'b0;
    always #5 clk_sampler = ~clk_sampler;

    logic       rst;
    logic [1:0] rst_req_n;
    logic [2:0] rst_out_n;
    logic       seq_done;
    logic [1:0] seq_state;
    logic [1:0] cause;

    logic       rst1;
    logic [0:0] req1_n;
    logic [0:0] out1_n;
    logic       done1;
    logic [1:0] state1;
    logic [0:0] cause1;

    rstseq #(.NCH(2), .NOUT(3), .SYNC_STAGES(2), .MIN_ASSERT(4), .GAP(3)) dut (
        .clk_sampler (clk_sampler),
        .rst         (rst),
        .rst_req_n   (rst_req_n),
        .rst_out_n   (rst_out_n),
        .seq_done    (seq_done),
        .seq_state   (seq_state),
        .cause       (cause)
    );

    rstseq #(.NCH(1), .NOUT(1), .SYNC_STAGES(2), .MIN_ASSERT(4), .GAP(3)) dut1 (
        .clk_sampler (clk_sampler),
        .rst         (rst1),
        .rst_req_n   (req1_n),
        .rst_out_n   (out1_n),
        .seq_done    (done1),
        .seq_state   (state1),
        .cause       (cause1)
    );

    typedef struct {
        logic       rst;
        logic [1:0] req_n;
        int         n;
        logic [2:0] out;
        logic       done;
        logic [1:0] st;
        logic [1:0] cause;
    } vec_t;

    typedef struct {
        int         step;
        logic [2:0] out;
        logic       done;
        logic [1:0] st;
        logic [1:0] cause;
    } exp_t;

    localparam int NV = 36;
    vec_t tbl [NV];
    exp_t sbq [$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int step, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s step=%0d got=%0h want=%0h", name, step, act, req);
        end
    endtask

    initial begin
        exp_t e;
        int   edge_no;
        int   done_edge;
        logic saw_release;
        logic out_at6;

        rst       = 1'b1;
        rst_req_n = 2'b11;
        rst1      = 1'b1;
        req1_n    = 1'b1;

        // power-up release schedule
        tbl[0]  = '{1'b1, 2'b11, 3, 3'b000, 1'b0, 2'd0, 2'b00};
        tbl[1]  = '{1'b0, 2'b11, 2, 3'b000, 1'b0, 2'd0, 2'b11};
        tbl[2]  = '{1'b0, 2'b11, 4, 3'b000, 1'b0, 2'd1, 2'b11};
        tbl[3]  = '{1'b0, 2'b11, 3, 3'b001, 1'b0, 2'd2, 2'b11};
        tbl[4]  = '{1'b0, 2'b11, 3, 3'b011, 1'b0, 2'd2, 2'b11};
        tbl[5]  = '{1'b0, 2'b11, 3, 3'b111, 1'b1, 2'd3, 2'b11};
        // rst while in DONE
        tbl[6]  = '{1'b1, 2'b11, 1, 3'b000, 1'b0, 2'd0, 2'b00};
        // mid-sequence request on channel 1
        tbl[7]  = '{1'b0, 2'b11, 2, 3'b000, 1'b0, 2'd0, 2'b11};
        tbl[8]  = '{1'b0, 2'b11, 4, 3'b000, 1'b0, 2'd1, 2'b11};
        tbl[9]  = '{1'b0, 2'b11, 2, 3'b001, 1'b0, 2'd2, 2'b11};
        tbl[10] = '{1'b0, 2'b01, 1, 3'b001, 1'b0, 2'd2, 2'b11};
        tbl[11] = '{1'b0, 2'b11, 1, 3'b011, 1'b0, 2'd2, 2'b11};
        tbl[12] = '{1'b0, 2'b11, 1, 3'b000, 1'b0, 2'd0, 2'b10};
        tbl[13] = '{1'b0, 2'b11, 4, 3'b000, 1'b0, 2'd1, 2'b10};
        tbl[14] = '{1'b0, 2'b11, 3, 3'b001, 1'b0, 2'd2, 2'b10};
        tbl[15] = '{1'b0, 2'b11, 3, 3'b011, 1'b0, 2'd2, 2'b10};
        tbl[16] = '{1'b0, 2'b11, 1, 3'b111, 1'b1, 2'd3, 2'b10};
        // both channels in DONE, then channel 0 alone
        tbl[17] = '{1'b0, 2'b00, 2, 3'b111, 1'b1, 2'd3, 2'b10};
        tbl[18] = '{1'b0, 2'b11, 1, 3'b000, 1'b0, 2'd0, 2'b11};
        tbl[19] = '{1'b0, 2'b11, 1, 3'b000, 1'b0, 2'd0, 2'b11};
        tbl[20] = '{1'b0, 2'b11, 4, 3'b000, 1'b0, 2'd1, 2'b11};
        tbl[21] = '{1'b0, 2'b11, 3, 3'b001, 1'b0, 2'd2, 2'b11};
        tbl[22] = '{1'b0, 2'b11, 3, 3'b011, 1'b0, 2'd2, 2'b11};
        tbl[23] = '{1'b0, 2'b11, 1, 3'b111, 1'b1, 2'd3, 2'b11};
        tbl[24] = '{1'b0, 2'b10, 1, 3'b111, 1'b1, 2'd3, 2'b11};
        tbl[25] = '{1'b0, 2'b11, 1, 3'b111, 1'b1, 2'd3, 2'b11};
        tbl[26] = '{1'b0, 2'b11, 1, 3'b000, 1'b0, 2'd0, 2'b01};
        tbl[27] = '{1'b0, 2'b11, 1, 3'b000, 1'b0, 2'd1, 2'b01};
        // glitch on channel 0 during HOLD restarts the minimum width
        tbl[28] = '{1'b1, 2'b11, 2, 3'b000, 1'b0, 2'd0, 2'b00};
        tbl[29] = '{1'b0, 2'b11, 2, 3'b000, 1'b0, 2'd0, 2'b11};
        tbl[30] = '{1'b0, 2'b11, 1, 3'b000, 1'b0, 2'd1, 2'b11};
        tbl[31] = '{1'b0, 2'b10, 1, 3'b000, 1'b0, 2'd1, 2'b11};
        tbl[32] = '{1'b0, 2'b11, 1, 3'b000, 1'b0, 2'd1, 2'b11};
        tbl[33] = '{1'b0, 2'b11, 1, 3'b000, 1'b0, 2'd0, 2'b11};
        tbl[34] = '{1'b0, 2'b11, 4, 3'b000, 1'b0, 2'd1, 2'b11};
        tbl[35] = '{1'b0, 2'b11, 1, 3'b001, 1'b0, 2'd2, 2'b11};

        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                @(negedge clk_sampler);
                rst       = tbl[i].rst;
                rst_req_n = tbl[i].req_n;
                sbq.push_back('{i, tbl[i].out, tbl[i].done, tbl[i].st, tbl[i].cause});
                @(posedge clk_sampler);
                #1;
                e = sbq.pop_front();
                check("rst_out_n", e.step, 32'(rst_out_n), 32'(e.out));
                check("seq_done",  e.step, 32'(seq_done),  32'(e.done));
                check("seq_state", e.step, 32'(seq_state), 32'(e.st));
                check("cause",     e.step, 32'(cause),     32'(e.cause));
                $display("step=%0d req_n=%b out=%b done=%b state=%0d cause=%b",
                         i, rst_req_n, rst_out_n, seq_done, seq_state, cause);
            end
        end

        // NOUT=1 build: single release together with seq_done, RELEASE never visited
        @(negedge clk_sampler);
        rst1 = 1'b1;
        repeat (2) @(posedge clk_sampler);
        @(negedge clk_sampler);
        rst1        = 1'b0;
        edge_no     = 0;
        done_edge   = 0;
        saw_release = 1'b0;
        out_at6     = 1'b1;
        while (edge_no < 20 && done_edge == 0) begin
            @(posedge clk_sampler);
            #1;
            edge_no++;
            if (state1 == 2'd2) saw_release = 1'b1;
            if (edge_no == 6) out_at6 = out1_n[0];
            if (done1) done_edge = edge_no;
        end
        $display("nout1: done_edge=%0d out=%b state=%0d cause=%b", done_edge, out1_n, state1, cause1);
        check("nout1_done_edge", 0, 32'(done_edge), 32'd7);
        check("nout1_out_before", 0, 32'(out_at6), 32'd0);
        check("nout1_out", 0, 32'(out1_n), 32'd1);
        check("nout1_state", 0, 32'(state1), 32'd3);
        check("nout1_no_release", 0, 32'(saw_release), 32'd0);
        check("nout1_cause", 0, 32'(cause1), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
